// File: rtl/noc_inject_ni_if.sv
// Handshake bundle between the PE, the injector and the router write port.
interface noc_inject_ni_if;
    logic        pe_valid;
    logic        pe_ready;
    logic [1:0]  pe_dest;
    logic [9:0]  pe_payload;
    logic        full;
    logic        almost_full;
    logic        write;
    logic [15:0] dataOut;

    // Injector side: consumes PE requests and router flow control, drives flits.
    modport slave (
        input  pe_valid, pe_dest, pe_payload, full, almost_full,
        output pe_ready, write, dataOut
    );

    // Environment side: PE plus router port.
    modport master (
        output pe_valid, pe_dest, pe_payload, full, almost_full,
        input  pe_ready, write, dataOut
    );
endinterface

// File: rtl/noc_inject_ni.sv
// Network-interface injector: buffers PE payloads in a small FIFO and emits
// formatted 16-bit flits on a router write port under full/almost_full control.
module noc_inject_ni #(
    parameter logic [1:0]  SRC_ID = 2'b10,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2
) (
    input  logic            clk,
    input  logic            reset,
    noc_inject_ni_if.slave  ni,
    output logic            bad_dest,
    output logic [15:0]     sent_cnt,
    output logic [AW:0]     pending
);

    typedef enum logic [1:0] {IDLE, SEND, BLOCKED} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [11:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           r_write;
    logic [15:0]    r_data;
    logic           r_bad;
    logic [15:0]    r_sent;

    logic           w_ready;
    logic           w_accept;
    logic           w_push;
    logic           w_go;
    logic [11:0]    w_head;

    // Ready depends only on the registered occupancy, so a same-cycle pop never raises it early.
    assign w_ready  = (r_count != (AW+1)'(DEPTH));
    assign w_accept = ni.pe_valid & w_ready;
    assign w_push   = w_accept & (ni.pe_dest != 2'b11);
    assign w_go     = (r_count != '0) & ~((r_write & ni.almost_full) | (~r_write & ni.full));
    assign w_head   = r_mem[r_rptr];

    assign ni.pe_ready = w_ready;
    assign ni.write    = r_write;
    assign ni.dataOut  = r_data;
    assign bad_dest    = r_bad;
    assign sent_cnt    = r_sent;
    assign pending     = r_count;

    // FIFO storage: entry holds {payload, dest}; formatting happens at pop time.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {ni.pe_payload, ni.pe_dest};
        end
    end

    // Pointers, occupancy and registered router-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_bad   <= 1'b0;
            r_sent  <= '0;
        end else begin
            r_bad <= w_accept & (ni.pe_dest == 2'b11);
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_go) begin
                r_rptr  <= r_rptr + AW'(1);
                r_write <= 1'b1;
                r_data  <= {1'b0, w_head[11:2], SRC_ID, w_head[1:0], 1'b1};
                r_sent  <= r_sent + 16'd1;
            end else begin
                r_write <= 1'b0;
            end
            case ({w_push, w_go})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: SEND tracks the write strobe; BLOCKED means data waits on flow control.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_go ? SEND : IDLE;
            SEND:    w_state_nxt = w_go ? SEND : ((r_count != '0) ? BLOCKED : IDLE);
            BLOCKED: w_state_nxt = w_go ? SEND : BLOCKED;
            default: w_state_nxt = IDLE;
        endcase
    end

    a_send_is_write: assert property (@(posedge clk) disable iff (reset)
        (r_state == SEND) == r_write);
    a_blocked_has_data: assert property (@(posedge clk) disable iff (reset)
        (r_state == BLOCKED) |-> (r_count != '0));
    a_idle_no_write: assert property (@(posedge clk) disable iff (reset)
        (r_state == IDLE) |-> !r_write);

endmodule

// File: tb/tb_noc_inject_ni.sv
// Scoreboard bench for noc_inject_ni: directed cases plus randomized traffic,
// checked against a transaction-level model of the FIFO and router flow control.
module tb_noc_inject_ni;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        bad_dest;
    logic [15:0] sent_cnt;
    logic [AW:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    noc_inject_ni_if intf ();

    noc_inject_ni #(.SRC_ID(2'b10), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ni       (intf.slave),
        .bad_dest (bad_dest),
        .sent_cnt (sent_cnt),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [11:0] q[$];
    logic [15:0] exp_q[$];
    logic        m_write;
    logic [15:0] m_data;
    logic [15:0] m_cnt;
    logic        m_bad;

    function automatic logic [15:0] fmt(input logic [11:0] e);
        return {1'b0, e[11:2], 2'b10, e[1:0], 1'b1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one edge of behaviour from the rules (flow control on previous write, FIFO order).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            exp_q.delete();
            m_write = 1'b0;
            m_data  = '0;
            m_cnt   = '0;
            m_bad   = 1'b0;
        end else begin
            int  sz;
            bit  acc;
            bit  go;
            sz  = q.size();
            acc = intf.pe_valid && (sz != DEPTH);
            go  = (sz != 0) && !((m_write && intf.almost_full) || (!m_write && intf.full));
            if (go) begin
                m_data  = fmt(q.pop_front());
                m_write = 1'b1;
                m_cnt   = m_cnt + 16'd1;
            end else begin
                m_write = 1'b0;
            end
            m_bad = acc && (intf.pe_dest == 2'b11);
            if (acc && intf.pe_dest != 2'b11) begin
                q.push_back({intf.pe_payload, intf.pe_dest});
                exp_q.push_back(fmt({intf.pe_payload, intf.pe_dest}));
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a flit.
    always @(negedge clk) begin
        check("write", 32'(intf.write), 32'(m_write));
        if (intf.write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 32'(intf.dataOut), 32'hDEAD_BEEF);
            end else begin
                check("flit", 32'(intf.dataOut), 32'(exp_q.pop_front()));
            end
        end
        check("dataOut", 32'(intf.dataOut), 32'(m_data));
        check("pending", 32'(pending), 32'(q.size()));
        check("pe_ready", 32'(intf.pe_ready), 32'(q.size() != DEPTH));
        check("bad_dest", 32'(bad_dest), 32'(m_bad));
        check("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d, input logic [9:0] p);
        intf.pe_valid   = 1'b1;
        intf.pe_dest    = d;
        intf.pe_payload = p;
        cyc();
        intf.pe_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        intf.pe_valid    = 1'b0;
        intf.full        = 1'b0;
        intf.almost_full = 1'b0;
        for (i = 0; i < 50; i++) begin
            if (pending == 0 && !intf.write) break;
            cyc();
        end
        if (i == 50) check("drain_timeout", 32'(pending), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        intf.pe_valid    = 1'b0;
        intf.pe_dest     = 2'b00;
        intf.pe_payload  = '0;
        intf.full        = 1'b0;
        intf.almost_full = 1'b0;
        cyc();
        check("rst_write", 32'(intf.write), 32'd0);
        check("rst_dataOut", 32'(intf.dataOut), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_sent", 32'(sent_cnt), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // Single push, router free.
        push(2'b01, 10'h005);
        cyc();
        check("single_write", 32'(intf.write), 32'd1);
        check("single_flit", 32'(intf.dataOut), 32'h00B3);
        check("single_sent", 32'(sent_cnt), 32'd1);
        drain();

        // Four back-to-back pushes.
        for (int i = 0; i < 4; i++) begin
            intf.pe_valid   = 1'b1;
            intf.pe_dest    = 2'(i % 3);
            intf.pe_payload = 10'(10'h100 + i);
            cyc();
        end
        intf.pe_valid = 1'b0;
        drain();
        check("b2b_sent", 32'(sent_cnt), 32'd5);

        // almost_full while writing, then full holds BLOCKED, then resume.
        for (int i = 0; i < 3; i++) begin
            intf.pe_valid   = 1'b1;
            intf.pe_dest    = 2'b10;
            intf.pe_payload = 10'(10'h2A0 + i);
            cyc();
        end
        intf.pe_valid    = 1'b0;
        intf.almost_full = 1'b1;
        intf.full        = 1'b1;
        cyc();
        check("af_stop", 32'(intf.write), 32'd0);
        cyc();
        check("full_hold", 32'(intf.write), 32'd0);
        intf.almost_full = 1'b0;
        intf.full        = 1'b0;
        cyc();
        check("resume", 32'(intf.write), 32'd1);
        drain();

        // Fill with full held.
        intf.full = 1'b1;
        for (int i = 0; i < 4; i++) push(2'b00, 10'(10'h3C0 + i));
        check("fill_pending", 32'(pending), 32'd4);
        check("fill_ready", 32'(intf.pe_ready), 32'd0);
        check("fill_nowrite", 32'(intf.write), 32'd0);
        drain();

        // Illegal destination.
        push(2'b11, 10'h3FF);
        check("bad_pulse", 32'(bad_dest), 32'd1);
        check("bad_pending", 32'(pending), 32'd0);
        cyc();
        check("bad_clear", 32'(bad_dest), 32'd0);
        check("bad_nowrite", 32'(intf.write), 32'd0);

        // Reset with flits pending mid-stream.
        intf.full = 1'b1;
        for (int i = 0; i < 3; i++) push(2'b01, 10'(10'h055 + i));
        intf.full = 1'b0;
        cyc();
        #2 reset = 1'b1;
        #1;
        check("midrst_write", 32'(intf.write), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_sent", 32'(sent_cnt), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        check("midrst_nostale", 32'(intf.write), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            intf.pe_valid    = ($urandom_range(0, 9) < 7);
            intf.pe_dest     = 2'($urandom_range(0, 3));
            intf.pe_payload  = 10'($urandom);
            intf.full        = ($urandom_range(0, 4) == 0);
            intf.almost_full = ($urandom_range(0, 4) == 0);
            cyc();
        end
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
